// File: rtl/apb_i2c_pkg.sv
// Shared constants for the APB I2C register front-end: register map, interrupt
// bit positions, STATUS field layout and the APB phase encoding.
package apb_i2c_pkg;

  localparam logic [31:0] OFF_TXDATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_RXDATA   = 32'h0000_0004;
  localparam logic [31:0] OFF_CONFIG   = 32'h0000_0008;
  localparam logic [31:0] OFF_TIMEOUT  = 32'h0000_000C;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_0010;
  localparam logic [31:0] OFF_INT_EN   = 32'h0000_0014;
  localparam logic [31:0] OFF_INT_STAT = 32'h0000_0018;

  localparam int unsigned IRQ_TXLOW  = 0;
  localparam int unsigned IRQ_RXHIGH = 1;
  localparam int unsigned IRQ_ERR    = 2;
  localparam int unsigned IRQ_RXOVF  = 3;
  localparam int unsigned IRQ_W      = 4;

  localparam int unsigned REG_W = 14;

  localparam int unsigned ST_TX_LSB   = 0;
  localparam int unsigned ST_RX_LSB   = 16;
  localparam int unsigned ST_CORE_ERR = 31;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_i2c_regif_if.sv
// APB3 bus bundle between the interconnect (master) and the I2C register front-end (slave).
interface apb_i2c_regif_if;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; push on full is accepted only when a pop
// frees a slot in the same cycle, pop on empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign level     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/apb_i2c_regif.sv
// APB3 slave front-end for the I2C core: TX/RX FIFOs, CONFIG/TIMEOUT/STATUS and
// interrupt registers, with protocol and access error reporting on PSLVERR.
module apb_i2c_regif
  import apb_i2c_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TX_THRESH  = 2,
  parameter int unsigned RX_THRESH  = 4
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_i2c_regif_if.slave     apb,
  input  logic               TX_RD,
  output logic [DATA_W-1:0]  TX_DATA,
  output logic               TX_EMPTY,
  input  logic               RX_WR,
  input  logic [DATA_W-1:0]  RX_DATA,
  output logic               RX_FULL,
  input  logic               CORE_ERROR,
  output logic [REG_W-1:0]   I2C_CONFIG,
  output logic [REG_W-1:0]   I2C_TIMEOUT,
  output logic               INT_TX,
  output logic               INT_RX,
  output logic               INT_ERR
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] TX_TH = LW'(TX_THRESH);
  localparam logic [LW-1:0] RX_TH = LW'(RX_THRESH);

  apb_state_e       r_state;
  apb_state_e       w_phase;
  logic [31:0]      r_addr;
  logic             r_write;
  logic             w_violation;
  logic             w_access;
  logic             w_err;
  logic [31:0]      w_rdata;
  logic [31:0]      w_status;
  logic             w_tx_push;
  logic             w_rx_pop;
  logic             w_cfg_we;
  logic             w_tmo_we;
  logic             w_en_we;
  logic [IRQ_W-1:0] w_w1c;
  logic [IRQ_W-1:0] w_set;

  logic [REG_W-1:0] r_config;
  logic [REG_W-1:0] r_timeout;
  logic [IRQ_W-1:0] r_int_en;
  logic [IRQ_W-1:0] r_int_stat;
  logic             r_core_err_d;
  logic             r_int_tx;
  logic             r_int_rx;
  logic             r_int_err;

  logic [DATA_W-1:0] w_rx_rdata;
  logic              w_tx_full;
  logic              w_rx_empty;
  logic [LW-1:0]     w_tx_level;
  logic [LW-1:0]     w_rx_level;
  logic              w_unused_ok;

  assign w_unused_ok = ^apb.PWDATA;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (w_tx_push),
    .pop   (TX_RD),
    .wdata (apb.PWDATA[DATA_W-1:0]),
    .rdata (TX_DATA),
    .full  (w_tx_full),
    .empty (TX_EMPTY),
    .level (w_tx_level)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (RX_WR),
    .pop   (w_rx_pop),
    .wdata (RX_DATA),
    .rdata (w_rx_rdata),
    .full  (RX_FULL),
    .empty (w_rx_empty),
    .level (w_rx_level)
  );

  // r_state holds the previous cycle's phase; the current phase is decoded
  // combinationally so that ACCESS completes with zero wait states.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_phase;
      if (w_phase == SETUP) begin
        r_addr  <= apb.PADDR;
        r_write <= apb.PWRITE;
      end
    end
  end

  always_comb begin
    w_phase     = IDLE;
    w_violation = 1'b0;
    if (!PRESET && apb.PSELx) begin
      if (apb.PENABLE) begin
        w_phase = ACCESS;
        if (r_state != SETUP)
          w_violation = 1'b1;
        else if (apb.PADDR != r_addr || apb.PWRITE != r_write)
          w_violation = 1'b1;
      end else begin
        w_phase = SETUP;
      end
    end
  end

  assign w_access = (w_phase == ACCESS);

  always_comb begin
    w_status = '0;
    w_status[ST_TX_LSB +: LW] = w_tx_level;
    w_status[ST_RX_LSB +: LW] = w_rx_level;
    w_status[ST_CORE_ERR]     = CORE_ERROR;
  end

  always_comb begin
    w_err     = w_violation;
    w_rdata   = '0;
    w_tx_push = 1'b0;
    w_rx_pop  = 1'b0;
    w_cfg_we  = 1'b0;
    w_tmo_we  = 1'b0;
    w_en_we   = 1'b0;
    w_w1c     = '0;
    if (w_access && !w_violation) begin
      case (apb.PADDR)
        OFF_TXDATA:
          if (!apb.PWRITE || w_tx_full) w_err = 1'b1;
          else                          w_tx_push = 1'b1;
        OFF_RXDATA:
          if (apb.PWRITE || w_rx_empty) w_err = 1'b1;
          else begin
            w_rx_pop = 1'b1;
            w_rdata  = 32'(w_rx_rdata);
          end
        OFF_CONFIG:
          if (apb.PWRITE) w_cfg_we = 1'b1;
          else            w_rdata  = 32'(r_config);
        OFF_TIMEOUT:
          if (apb.PWRITE) w_tmo_we = 1'b1;
          else            w_rdata  = 32'(r_timeout);
        OFF_STATUS:
          if (apb.PWRITE) w_err   = 1'b1;
          else            w_rdata = w_status;
        OFF_INT_EN:
          if (apb.PWRITE) w_en_we = 1'b1;
          else            w_rdata = 32'(r_int_en);
        OFF_INT_STAT:
          if (apb.PWRITE) w_w1c   = apb.PWDATA[IRQ_W-1:0];
          else            w_rdata = 32'(r_int_stat);
        default:
          w_err = 1'b1;
      endcase
    end
  end

  assign apb.PREADY  = w_access;
  assign apb.PSLVERR = w_access & w_err;
  assign apb.PRDATA  = w_rdata;

  always_comb begin
    w_set             = '0;
    w_set[IRQ_TXLOW]  = (w_tx_level <= TX_TH);
    w_set[IRQ_RXHIGH] = (w_rx_level >= RX_TH);
    w_set[IRQ_ERR]    = CORE_ERROR & ~r_core_err_d;
    w_set[IRQ_RXOVF]  = RX_WR & RX_FULL & ~w_rx_pop;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_config     <= '0;
      r_timeout    <= '0;
      r_int_en     <= '0;
      r_int_stat   <= '0;
      r_core_err_d <= 1'b0;
      r_int_tx     <= 1'b0;
      r_int_rx     <= 1'b0;
      r_int_err    <= 1'b0;
    end else begin
      if (w_cfg_we) r_config  <= apb.PWDATA[REG_W-1:0];
      if (w_tmo_we) r_timeout <= apb.PWDATA[REG_W-1:0];
      if (w_en_we)  r_int_en  <= apb.PWDATA[IRQ_W-1:0];
      // A set in the same cycle as the W1C wins.
      r_int_stat   <= (r_int_stat & ~w_w1c) | w_set;
      r_core_err_d <= CORE_ERROR;
      r_int_tx     <= r_int_stat[IRQ_TXLOW] & r_int_en[IRQ_TXLOW];
      r_int_rx     <= r_int_stat[IRQ_RXHIGH] & r_int_en[IRQ_RXHIGH];
      r_int_err    <= (r_int_stat[IRQ_ERR] & r_int_en[IRQ_ERR]) |
                      (r_int_stat[IRQ_RXOVF] & r_int_en[IRQ_RXOVF]);
    end
  end

  assign I2C_CONFIG  = r_config;
  assign I2C_TIMEOUT = r_timeout;
  assign INT_TX      = r_int_tx;
  assign INT_RX      = r_int_rx;
  assign INT_ERR     = r_int_err;
endmodule

// File: tb/tb_apb_i2c_regif.sv
// Directed self-checking bench for apb_i2c_regif (DATA_W=8, depth 8, thresholds 2/4).
module tb_apb_i2c_regif;
  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        TX_RD = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_EMPTY;
  logic        RX_WR = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        RX_FULL;
  logic        CORE_ERROR = 1'b0;
  logic [13:0] I2C_CONFIG;
  logic [13:0] I2C_TIMEOUT;
  logic        INT_TX, INT_RX, INT_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_i2c_regif_if bus ();

  apb_i2c_regif #(
    .DATA_W     (8),
    .FIFO_DEPTH (8),
    .TX_THRESH  (2),
    .RX_THRESH  (4)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .apb         (bus.slave),
    .TX_RD       (TX_RD),
    .TX_DATA     (TX_DATA),
    .TX_EMPTY    (TX_EMPTY),
    .RX_WR       (RX_WR),
    .RX_DATA     (RX_DATA),
    .RX_FULL     (RX_FULL),
    .CORE_ERROR  (CORE_ERROR),
    .I2C_CONFIG  (I2C_CONFIG),
    .I2C_TIMEOUT (I2C_TIMEOUT),
    .INT_TX      (INT_TX),
    .INT_RX      (INT_RX),
    .INT_ERR     (INT_ERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0;   bus.PWDATA = '0;
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int unsigned n;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #1;
    n = 0;
    while (bus.PREADY !== 1'b1 && n < 8) begin @(posedge PCLK); #2; n++; end
    if (n == 8) begin
      n_tests++; n_fail++;
      $display("FAIL apb_timeout addr=%h got PREADY=%b required 1", addr, bus.PREADY);
    end
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(posedge PCLK); #1; RX_WR = 1'b1; RX_DATA = d;
    @(posedge PCLK); #1; RX_WR = 1'b0;
  endtask

  task automatic tx_pop();
    @(posedge PCLK); #1; TX_RD = 1'b1;
    @(posedge PCLK); #1; TX_RD = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++; if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.PRDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus got rdy=%b err=%b rdata=%h required 0/0/0", bus.PREADY, bus.PSLVERR, bus.PRDATA); end
    n_tests++; if (TX_EMPTY !== 1'b1 || RX_FULL !== 1'b0) begin
      n_fail++; $display("FAIL reset_fifo got tx_empty=%b rx_full=%b required 1/0", TX_EMPTY, RX_FULL); end
    n_tests++; if ({INT_TX, INT_RX, INT_ERR} !== 3'b000 || I2C_CONFIG !== 14'h0 || I2C_TIMEOUT !== 14'h0) begin
      n_fail++; $display("FAIL reset_regs got int=%b cfg=%h tmo=%h required 000/0/0", {INT_TX, INT_RX, INT_ERR}, I2C_CONFIG, I2C_TIMEOUT); end
    PRESET = 1'b0;
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL reset_status got rdata=%h err=%b required 00000000/0", rd, er); end
  endtask

  task automatic test_config();
    logic [31:0] rd; logic er;
    apb_xfer(1'b1, 32'h08, 32'h0000_3ABC, rd, er);
    n_tests++; if (I2C_CONFIG !== 14'h3ABC || er !== 1'b0) begin
      n_fail++; $display("FAIL cfg_write got cfg=%h err=%b required 3abc/0", I2C_CONFIG, er); end
    apb_xfer(1'b0, 32'h08, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h0000_3ABC || er !== 1'b0) begin
      n_fail++; $display("FAIL cfg_read got %h err=%b required 00003abc/0", rd, er); end
    apb_xfer(1'b1, 32'h0C, 32'hFFFF_FFFF, rd, er);
    n_tests++; if (I2C_TIMEOUT !== 14'h3FFF) begin
      n_fail++; $display("FAIL tmo_write got %h required 3fff", I2C_TIMEOUT); end
    apb_xfer(1'b0, 32'h0C, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h0000_3FFF) begin
      n_fail++; $display("FAIL tmo_read got %h required 00003fff", rd); end
  endtask

  task automatic test_tx_fifo();
    logic [31:0] rd; logic er;
    for (int i = 0; i < 9; i++) begin
      apb_xfer(1'b1, 32'h00, {24'hABCDEF, 8'(8'h10 + i)}, rd, er);
      n_tests++; if (er !== (i == 8)) begin
        n_fail++; $display("FAIL tx_write%0d got err=%b required %b", i, er, (i == 8)); end
    end
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h0000_0008) begin
      n_fail++; $display("FAIL tx_level_full got %h required 00000008", rd); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (TX_DATA !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL tx_order%0d got %h required %h", i, TX_DATA, 8'(8'h10 + i)); end
      tx_pop();
    end
    n_tests++; if (TX_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL tx_empty got %b required 1", TX_EMPTY); end
  endtask

  task automatic test_rx_fifo();
    logic [31:0] rd; logic er;
    apb_xfer(1'b0, 32'h04, 32'h0, rd, er);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL rx_empty_read got err=%b rdata=%h required 1/0", er, rd); end
    rx_push(8'hA5);
    apb_xfer(1'b0, 32'h04, 32'h0, rd, er);
    n_tests++; if (er !== 1'b0 || rd !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL rx_read got err=%b rdata=%h required 0/000000a5", er, rd); end
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h0) begin
      n_fail++; $display("FAIL rx_level_after got %h required 00000000", rd); end
  endtask

  task automatic test_interrupts();
    logic [31:0] rd; logic er;
    apb_xfer(1'b1, 32'h14, 32'h0000_000F, rd, er);
    repeat (2) @(posedge PCLK);
    #1;
    n_tests++; if (INT_TX !== 1'b1 || INT_RX !== 1'b0 || INT_ERR !== 1'b0) begin
      n_fail++; $display("FAIL int_idle got tx/rx/err=%b%b%b required 100", INT_TX, INT_RX, INT_ERR); end
    for (int i = 1; i <= 4; i++) rx_push(8'(i));
    n_tests++; if (INT_RX !== 1'b0) begin
      n_fail++; $display("FAIL int_rx_early0 got %b required 0", INT_RX); end
    @(posedge PCLK); #1;
    n_tests++; if (INT_RX !== 1'b0) begin
      n_fail++; $display("FAIL int_rx_early1 got %b required 0", INT_RX); end
    @(posedge PCLK); #1;
    n_tests++; if (INT_RX !== 1'b1) begin
      n_fail++; $display("FAIL int_rx_set got %b required 1", INT_RX); end
    apb_xfer(1'b0, 32'h04, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h1) begin
      n_fail++; $display("FAIL int_pop got %h required 00000001", rd); end
    apb_xfer(1'b1, 32'h18, 32'h0000_0002, rd, er);
    repeat (2) @(posedge PCLK);
    #1;
    n_tests++; if (INT_RX !== 1'b0) begin
      n_fail++; $display("FAIL int_rx_clear got %b required 0", INT_RX); end
    apb_xfer(1'b0, 32'h18, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h1) begin
      n_fail++; $display("FAIL int_stat_a got %h required 00000001", rd); end
    @(posedge PCLK); #1; CORE_ERROR = 1'b1;
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h8003_0000) begin
      n_fail++; $display("FAIL status_core_err got %h required 80030000", rd); end
    CORE_ERROR = 1'b0;
    @(posedge PCLK); #1;
    n_tests++; if (INT_ERR !== 1'b1) begin
      n_fail++; $display("FAIL int_err_set got %b required 1", INT_ERR); end
    apb_xfer(1'b0, 32'h18, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h5) begin
      n_fail++; $display("FAIL int_stat_b got %h required 00000005", rd); end
    apb_xfer(1'b1, 32'h18, 32'h0000_0004, rd, er);
    repeat (2) @(posedge PCLK);
    #1;
    n_tests++; if (INT_ERR !== 1'b0) begin
      n_fail++; $display("FAIL int_err_clear got %b required 0", INT_ERR); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] rd; logic er;
    logic [7:0] exp_q [8];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    for (int i = 0; i < 5; i++) rx_push(8'(8'h20 + i));
    n_tests++; if (RX_FULL !== 1'b1) begin
      n_fail++; $display("FAIL rx_full got %b required 1", RX_FULL); end
    rx_push(8'hEE);
    repeat (2) @(posedge PCLK);
    #1;
    n_tests++; if (INT_ERR !== 1'b1) begin
      n_fail++; $display("FAIL rxovf_int got %b required 1", INT_ERR); end
    apb_xfer(1'b0, 32'h18, 32'h0, rd, er);
    n_tests++; if (rd !== 32'hB) begin
      n_fail++; $display("FAIL rxovf_stat got %h required 0000000b", rd); end
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1'b0, 32'h04, 32'h0, rd, er);
      n_tests++; if (rd !== 32'(exp_q[i]) || er !== 1'b0) begin
        n_fail++; $display("FAIL rx_drain%0d got %h err=%b required %h/0", i, rd, er, exp_q[i]); end
    end
    apb_xfer(1'b0, 32'h04, 32'h0, rd, er);
    n_tests++; if (er !== 1'b1) begin
      n_fail++; $display("FAIL rx_drained_read got err=%b required 1", er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 32'h08; bus.PWDATA = 32'h1234;
    #1;
    n_tests++; if (bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b1 || bus.PRDATA !== 32'h0) begin
      n_fail++; $display("FAIL no_setup got rdy=%b err=%b rdata=%h required 1/1/0", bus.PREADY, bus.PSLVERR, bus.PRDATA); end
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    n_tests++; if (I2C_CONFIG !== 14'h3ABC) begin
      n_fail++; $display("FAIL no_setup_effect got cfg=%h required 3abc", I2C_CONFIG); end
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 32'h08; bus.PWDATA = 32'h1111;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1; bus.PADDR = 32'h0C;
    #1;
    n_tests++; if (bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b1) begin
      n_fail++; $display("FAIL addr_change got rdy=%b err=%b required 1/1", bus.PREADY, bus.PSLVERR); end
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    n_tests++; if (I2C_CONFIG !== 14'h3ABC || I2C_TIMEOUT !== 14'h3FFF) begin
      n_fail++; $display("FAIL addr_change_effect got cfg=%h tmo=%h required 3abc/3fff", I2C_CONFIG, I2C_TIMEOUT); end
    apb_xfer(1'b0, 32'h20, 32'h0, rd, er);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL unmapped got err=%b rdata=%h required 1/0", er, rd); end
    apb_xfer(1'b1, 32'h09, 32'h0, rd, er);
    n_tests++; if (er !== 1'b1 || I2C_CONFIG !== 14'h3ABC) begin
      n_fail++; $display("FAIL unaligned got err=%b cfg=%h required 1/3abc", er, I2C_CONFIG); end
    apb_xfer(1'b1, 32'h10, 32'h0, rd, er);
    n_tests++; if (er !== 1'b1) begin
      n_fail++; $display("FAIL status_write got err=%b required 1", er); end
    apb_xfer(1'b1, 32'h04, 32'h0, rd, er);
    n_tests++; if (er !== 1'b1) begin
      n_fail++; $display("FAIL rxdata_write got err=%b required 1", er); end
    apb_xfer(1'b0, 32'h00, 32'h0, rd, er);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL txdata_read got err=%b rdata=%h required 1/0", er, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h08; bus.PWDATA = 32'h11;
    @(posedge PCLK); #1; bus.PENABLE = 1'b1; #1;
    n_tests++; if (bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first got rdy=%b err=%b required 1/0", bus.PREADY, bus.PSLVERR); end
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b0; bus.PADDR = 32'h0C; bus.PWDATA = 32'h22;
    @(posedge PCLK); #1; bus.PENABLE = 1'b1; #1;
    n_tests++; if (bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got rdy=%b err=%b required 1/0", bus.PREADY, bus.PSLVERR); end
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    n_tests++; if (I2C_CONFIG !== 14'h11 || I2C_TIMEOUT !== 14'h22) begin
      n_fail++; $display("FAIL b2b_regs got cfg=%h tmo=%h required 0011/0022", I2C_CONFIG, I2C_TIMEOUT); end
    apb_xfer(1'b1, 32'h00, 32'h77, rd, er);
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'h88;
    @(posedge PCLK); #1; bus.PENABLE = 1'b1; TX_RD = 1'b1;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0; TX_RD = 1'b0;
    n_tests++; if (TX_DATA !== 8'h88 || TX_EMPTY !== 1'b0) begin
      n_fail++; $display("FAIL push_pop_head got %h empty=%b required 88/0", TX_DATA, TX_EMPTY); end
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h1) begin
      n_fail++; $display("FAIL push_pop_level got %h required 00000001", rd); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er;
    apb_xfer(1'b1, 32'h00, 32'h55, rd, er);
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'h66;
    @(posedge PCLK); #1; bus.PENABLE = 1'b1; PRESET = 1'b1; #1;
    n_tests++; if (bus.PREADY !== 1'b0) begin
      n_fail++; $display("FAIL rst_access_ready got %b required 0", bus.PREADY); end
    @(posedge PCLK); #1;
    PRESET = 1'b0; bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    n_tests++; if (TX_EMPTY !== 1'b1 || I2C_CONFIG !== 14'h0) begin
      n_fail++; $display("FAIL rst_access_state got empty=%b cfg=%h required 1/0", TX_EMPTY, I2C_CONFIG); end
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er);
    n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL rst_access_level got %h err=%b required 00000000/0", rd, er); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_tx_fifo();
    test_rx_fifo();
    test_interrupts();
    test_rx_overflow();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion required finish within 200000ns");
    $fatal(1);
  end
endmodule

// File: doc/apb_i2c_regif.md
Name: apb_i2c_regif

Overview:
Parameterised APB3 slave front-end for the I2C core, succeeding the fixed 32-bit pass-through bridge. It holds on-chip TX and RX FIFOs of configurable width and depth, plus the CONFIG, TIMEOUT, STATUS and interrupt registers. It detects protocol and access errors and drives PSLVERR. It sits between the APB interconnect and the I2C core, which pops TX data and pushes RX data through simple valid/ready-free strobes.

Parameters:
DATA_W, 8, FIFO data width (1..32); upper PWDATA bits ignored, PRDATA zero-extended.
FIFO_DEPTH, 8, entries per FIFO; power of two, >= 2.
TX_THRESH, 2, TX low-water mark: tx_level <= TX_THRESH sets TXLOW.
RX_THRESH, 4, RX high-water mark: rx_level >= RX_THRESH sets RXHIGH.

Ports:
PCLK  in  1  clock; all logic rising-edge.
PRESET  in  1  synchronous reset, active-high.
PSELx, PENABLE, PWRITE  in  1 each  APB3 controls.
PADDR  in  32  byte address, full decode.
PWDATA  in  32  write data.
PRDATA  out  32  read data.
PREADY  out  1  transfer complete.
PSLVERR  out  1  transfer error, valid only when PREADY=1.
TX_RD  in  1  core pops TX head.
TX_DATA  out  DATA_W  TX head (first-word fall-through).
TX_EMPTY  out  1  TX FIFO empty.
RX_WR  in  1  core pushes RX_DATA.
RX_DATA  in  DATA_W  data from core.
RX_FULL  out  1  RX FIFO full.
CORE_ERROR  in  1  core error level.
I2C_CONFIG  out  14  CONFIG register.
I2C_TIMEOUT  out  14  TIMEOUT register.
INT_TX, INT_RX, INT_ERR  out  1 each  interrupt lines.

Behaviour:
- Reset (PRESET=1 at a PCLK edge): FIFOs empty, CONFIG/TIMEOUT/INT_EN/INT_STAT=0, FSM=IDLE. Outputs: PREADY=0, PSLVERR=0, PRDATA=0, TX_EMPTY=1, RX_FULL=0, INT_*=0. A transfer in flight during reset is dropped with no side effect.
- APB FSM: IDLE -> SETUP on PSELx&!PENABLE; SETUP -> ACCESS when PENABLE=1; ACCESS -> SETUP if PSELx stays high, else IDLE.
- Protocol violation: PENABLE=1 in IDLE, or PADDR/PWRITE changing between SETUP and ACCESS. The access completes with PSLVERR=1 and no side effect.
- PREADY: combinational, 1 in ACCESS only; zero wait states. Side effects commit on the ACCESS cycle edge, exactly once per transfer.
- Register map:
  - 0x00 TXDATA (W): push PWDATA[DATA_W-1:0].
  - 0x04 RXDATA (R): pop head.
  - 0x08 CONFIG (RW, 14b).
  - 0x0C TIMEOUT (RW, 14b).
  - 0x10 STATUS (R): [LW-1:0] tx_level, [LW+15:16] rx_level, bit31 CORE_ERROR. LW = clog2(FIFO_DEPTH)+1.
  - 0x14 INT_EN (RW, 4b).
  - 0x18 INT_STAT (R/W1C, 4b): bit0 TXLOW, bit1 RXHIGH, bit2 ERR (CORE_ERROR rising edge), bit3 RXOVF.
- PSLVERR=1, no side effect, on any of: unmapped address; write to 0x04/0x10; read of 0x00; TXDATA write when TX full; RXDATA read when RX empty. PRDATA=0 on error.
- Simultaneous push and pop on one FIFO: both occur and level is unchanged. Pop-on-empty and push-on-full are blocked. RX_WR while full drops the data and sets RXOVF. TX_RD on empty is ignored.
- TXLOW/RXHIGH set each cycle the condition holds. W1C clears a bit, but a set in the same cycle wins.
- Interrupt mapping: INT_TX = stat[0]&en[0]; INT_RX = stat[1]&en[1]; INT_ERR = (stat[2]&en[2]) | (stat[3]&en[3]). All registered; 1 cycle after the status bit sets.
- Pointers wrap modulo FIFO_DEPTH. Level counts 0..FIFO_DEPTH.

Decomposition:
- Package apb_i2c_pkg:
  - register offsets;
  - INT_STAT bit indices;
  - FSM state enum {IDLE, SETUP, ACCESS};
  - STATUS field positions.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty, level. Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then read 0x10 -> PRDATA=0x0000_0000, PSLVERR=0, TX_EMPTY=1.
- Write 0x08=0x3ABC, then read 0x08 -> I2C_CONFIG=0x3ABC, PRDATA=0x0000_3ABC. Write 0x0C=0xFFFF_FFFF -> I2C_TIMEOUT=0x3FFF.
- Write TXDATA 9 times with DATA_W=8, depth 8: writes 1-8 OK; write 9 -> PSLVERR=1, tx_level stays 8. Then pulse TX_RD 8 times -> TX_DATA follows write order, TX_EMPTY=1.
- Read 0x04 while RX empty -> PSLVERR=1, PRDATA=0. Push 0xA5 via RX_WR, read 0x04 -> PRDATA=0x0000_00A5, rx_level=0.
- INT_EN=0xF; push 4 RX words -> INT_RX=1 one cycle after RXHIGH sets. Pop 1 word, write INT_STAT=0x2 -> INT_RX=0. Pulse CORE_ERROR -> INT_ERR=1.
- PSELx=1, PENABLE=1 with no SETUP cycle; read 0x20; assert PRESET mid-ACCESS of a TXDATA write -> each error case gives PSLVERR=1; the reset case gives tx_level=0.
